// File: rtl/am_trainer_pkg.sv
// Shared constants for the associative-memory prototype trainer.
// Optional build macro used by the trainer: AM_TRAINER_AUTOCLEAR_EN.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

package am_trainer_pkg;

  localparam int DEF_NUM_FOLDS       = 10;
  localparam int DEF_NUM_FOLDS_WIDTH = 4;
  localparam int DEF_FOLD_WIDTH      = 200;
  localparam int DEF_COUNT_WIDTH     = 8;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCUM  = 2'd1;
  localparam state_t THRESH = 2'd2;
  localparam state_t OUT    = 2'd3;

  typedef logic [1:0] class_id_t;
  localparam class_id_t V_PLUS = 2'd0;
  localparam class_id_t V_MIN  = 2'd1;
  localparam class_id_t A_HIGH = 2'd2;
  localparam class_id_t A_LOW  = 2'd3;

  localparam logic [DEF_COUNT_WIDTH-1:0] COUNT_MAX = {DEF_COUNT_WIDTH{1'b1}};

endpackage

// File: rtl/hv_majority_fold.sv
// Majority threshold of one fold of per-bit counters against a class sample count.
// A bit is set only when strictly more than half of the samples had it set.
module hv_majority_fold
  import am_trainer_pkg::*;
#(
  parameter int FOLD_WIDTH  = DEF_FOLD_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic [FOLD_WIDTH-1:0][COUNT_WIDTH-1:0] cnt,
  input  logic [COUNT_WIDTH-1:0]                 n,
  output logic [FOLD_WIDTH-1:0]                  maj
);

  // Compare 2*cnt against n one bit wider so the doubling cannot overflow.
  always_comb begin
    maj = '0;
    for (int i = 0; i < FOLD_WIDTH; i++) begin
      maj[i] = (n != '0) && ({cnt[i], 1'b0} > {1'b0, n});
    end
  end

endmodule

// File: rtl/am_prototype_trainer.sv
// Accumulates labelled hypervectors per class and streams majority prototypes in AM order.
// Build macro AM_TRAINER_AUTOCLEAR_EN: clear all counts after the last prototype handshake.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

module am_prototype_trainer
  import am_trainer_pkg::*;
#(
  parameter int AM_NUM_FOLDS       = DEF_NUM_FOLDS,
  parameter int AM_NUM_FOLDS_WIDTH = DEF_NUM_FOLDS_WIDTH,
  parameter int AM_FOLD_WIDTH      = DEF_FOLD_WIDTH,
  parameter int COUNT_WIDTH        = DEF_COUNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hvin_valid,
  output logic                       hvin_ready,
  input  logic [`HV_DIMENSION-1:0]   hvin,
  input  logic                       valence_label,
  input  logic                       arousal_label,
  input  logic                       finalize_valid,
  output logic                       finalize_ready,
  output logic                       proto_valid,
  input  logic                       proto_ready,
  output logic [1:0]                 proto_id,
  output logic [`HV_DIMENSION-1:0]   proto_hv
);

  localparam logic [AM_NUM_FOLDS_WIDTH-1:0] LAST_FOLD = AM_NUM_FOLDS_WIDTH'(AM_NUM_FOLDS - 1);
  localparam logic [COUNT_WIDTH-1:0]        CNT_MAX   = {COUNT_WIDTH{1'b1}};

  state_t                                          state;
  logic [AM_NUM_FOLDS_WIDTH-1:0]                   fold_counter;
  logic [AM_NUM_FOLDS-1:0][AM_FOLD_WIDTH-1:0]      hv_lat;
  logic [AM_NUM_FOLDS-1:0][AM_FOLD_WIDTH-1:0]      proto_folds;
  class_id_t                                       cls_v;
  class_id_t                                       cls_a;
  logic                                            upd_v;
  logic                                            upd_a;
  logic [AM_FOLD_WIDTH-1:0][COUNT_WIDTH-1:0]       cnt [4][AM_NUM_FOLDS];
  logic [COUNT_WIDTH-1:0]                          n_cnt [4];
  logic [3:0]                                      target;
  logic [AM_FOLD_WIDTH-1:0]                        fold_bits;
  logic [AM_FOLD_WIDTH-1:0]                        maj_bits;
  class_id_t                                       fire_cv;
  class_id_t                                       fire_ca;
  logic                                            last_fire;
  logic                                            clear_all;

  assign finalize_ready = (state == IDLE);
  assign hvin_ready     = (state == IDLE) && !finalize_valid;
  assign proto_hv       = proto_folds;
  assign fire_cv        = valence_label ? V_PLUS : V_MIN;
  assign fire_ca        = arousal_label ? A_HIGH : A_LOW;
  assign fold_bits      = hv_lat[fold_counter];
  assign last_fire      = (state == OUT) && proto_ready && (proto_id == A_LOW);

`ifdef AM_TRAINER_AUTOCLEAR_EN
  assign clear_all = last_fire;
`else
  assign clear_all = 1'b0;
`endif

  // Classes receiving the latched sample; frozen classes drop out here.
  always_comb begin
    target = 4'b0000;
    target[cls_v] = upd_v;
    target[cls_a] = upd_a;
  end

  hv_majority_fold #(
    .FOLD_WIDTH  (AM_FOLD_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_majority (
    .cnt (cnt[proto_id][fold_counter]),
    .n   (n_cnt[proto_id]),
    .maj (maj_bits)
  );

  // Control FSM: arbitration, fold sequencing and prototype handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fold_counter <= '0;
      proto_id     <= V_PLUS;
      proto_valid  <= 1'b0;
      proto_folds  <= '0;
      hv_lat       <= '0;
      cls_v        <= V_PLUS;
      cls_a        <= A_HIGH;
      upd_v        <= 1'b0;
      upd_a        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fold_counter <= '0;
          if (finalize_valid) begin
            proto_id <= V_PLUS;
            state    <= THRESH;
          end else if (hvin_valid) begin
            hv_lat <= hvin;
            cls_v  <= fire_cv;
            cls_a  <= fire_ca;
            upd_v  <= (n_cnt[fire_cv] != CNT_MAX);
            upd_a  <= (n_cnt[fire_ca] != CNT_MAX);
            state  <= ACCUM;
          end else begin
            state <= IDLE;
          end
        end
        ACCUM: begin
          if (fold_counter == LAST_FOLD) begin
            fold_counter <= '0;
            state        <= IDLE;
          end else begin
            fold_counter <= fold_counter + 1'b1;
          end
        end
        THRESH: begin
          proto_folds[fold_counter] <= maj_bits;
          if (fold_counter == LAST_FOLD) begin
            fold_counter <= '0;
            proto_valid  <= 1'b1;
            state        <= OUT;
          end else begin
            fold_counter <= fold_counter + 1'b1;
          end
        end
        OUT: begin
          if (proto_ready) begin
            proto_valid <= 1'b0;
            if (proto_id == A_LOW) begin
              proto_id <= V_PLUS;
              state    <= IDLE;
            end else begin
              proto_id <= proto_id + 1'b1;
              state    <= THRESH;
            end
          end else begin
            state <= OUT;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Per-bit and per-class counters; sample counts bump on the last fold.
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      for (int c = 0; c < 4; c++) begin
        n_cnt[c] <= '0;
        for (int f = 0; f < AM_NUM_FOLDS; f++) begin
          cnt[c][f] <= '0;
        end
      end
    end else if (state == ACCUM) begin
      for (int c = 0; c < 4; c++) begin
        if (target[c]) begin
          for (int i = 0; i < AM_FOLD_WIDTH; i++) begin
            if (fold_bits[i] && (cnt[c][fold_counter][i] != CNT_MAX)) begin
              cnt[c][fold_counter][i] <= cnt[c][fold_counter][i] + 1'b1;
            end
          end
          if (fold_counter == LAST_FOLD) begin
            n_cnt[c] <= n_cnt[c] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/am_prototype_trainer.md
# am_prototype_trainer

- Training-side counterpart of the associative memory: builds the four class prototype hypervectors that the AM compares against.
- Accepts labelled query hypervectors from the encoder path and accumulates per-class, per-bit counts fold by fold.
- On a finalize request, majority-thresholds each class and streams the four prototypes out in AM order: V_PLUS, V_MIN, A_HIGH, A_LOW.
- Sits beside the associative memory, fed by the same spatial/temporal encoder output.

## Interface
- AM_NUM_FOLDS, 10, number of folds per hypervector; AM_NUM_FOLDS * AM_FOLD_WIDTH == `HV_DIMENSION
- AM_NUM_FOLDS_WIDTH, 4, fold counter width
- AM_FOLD_WIDTH, 200, bits processed per cycle
- COUNT_WIDTH, 8, width of per-bit counters and per-class sample counts
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- hvin_valid  in  1  training sample valid
- hvin_ready  out  1  sample accepted when high with hvin_valid
- hvin  in  `HV_DIMENSION  training hypervector
- valence_label  in  1  1 = V_PLUS, 0 = V_MIN; sampled with hvin
- arousal_label  in  1  1 = A_HIGH, 0 = A_LOW; sampled with hvin
- finalize_valid  in  1  request prototype generation
- finalize_ready  out  1  finalize accepted when high with finalize_valid
- proto_valid  out  1  prototype output valid
- proto_ready  in  1  downstream accepts prototype
- proto_id  out  2  0 V_PLUS, 1 V_MIN, 2 A_HIGH, 3 A_LOW
- proto_hv  out  `HV_DIMENSION  prototype hypervector

## Operation
- Storage: cnt[c][b], COUNT_WIDTH each, for 4 classes × `HV_DIMENSION bits; n[c], COUNT_WIDTH each.
- States:
  - IDLE: hvin_ready = finalize_ready = 1.
  - ACCUM: folds 0..AM_NUM_FOLDS-1.
  - THRESH: one prototype, folds 0..AM_NUM_FOLDS-1.
  - OUT: proto_valid high.
- Arbitration in IDLE: if hvin_valid and finalize_valid are both high, finalize wins and hvin_ready is 0 in that cycle.
- hvin fire:
  - Latch hvin and labels.
  - Target classes: cv = valence_label ? 0 : 1; ca = arousal_label ? 2 : 3.
  - Go to ACCUM with fold_counter = 0.
- ACCUM, each cycle, for each target class:
  - For every bit b in fold f set in hvin, cnt[c][b] += 1.
  - Counters saturate at 2^COUNT_WIDTH-1.
- ACCUM last fold:
  - n[cv] += 1 and n[ca] += 1.
  - Return to IDLE.
- Sample-count saturation:
  - If n[c] == 2^COUNT_WIDTH-1 at hvin fire, class c is frozen for that sample: neither cnt nor n updated.
  - The other target class updates normally.
- finalize fire: go to THRESH with proto_id = 0.
- THRESH, each cycle: proto_hv fold f bit = (2*cnt[c][b] > n[c]).
  - Comparison in COUNT_WIDTH+1 bits.
  - Tie gives 0.
  - n[c] == 0 gives an all-zero prototype.
- THRESH last fold: go to OUT.
- OUT:
  - proto_valid = 1; proto_hv and proto_id held stable until proto_ready.
  - On fire with proto_id < 3: proto_id += 1, go to THRESH.
  - On fire with proto_id == 3: go to IDLE.
- Counters persist across finalize: prototypes reflect all samples since reset or last clear.

## Timing
- Reset values:
  - State IDLE, fold_counter 0, proto_id 0.
  - proto_valid 0, proto_hv 0.
  - All cnt and n are 0.
  - hvin_ready and finalize_ready are 1 in the first cycle after reset.
- Sample throughput:
  - Fire at cycle t; folds occupy t+1..t+AM_NUM_FOLDS.
  - hvin_ready is high again at t+AM_NUM_FOLDS+1.
- Prototype latency:
  - Finalize fire at t gives proto_valid at t+AM_NUM_FOLDS+1.
  - Each later prototype arrives AM_NUM_FOLDS+1 cycles after the previous proto fire, assuming proto_ready is held high.
- proto_ready low: the block stalls in OUT indefinitely; no state change.
- rst mid-ACCUM or mid-THRESH:
  - Aborts the operation and clears all counters.
  - proto_valid drops on the next edge.

## Configuration
- Macro: AM_TRAINER_AUTOCLEAR_EN.
- Defined: the proto_id 3 fire also zeroes every cnt and n in that same cycle, so each finalize starts a fresh training epoch.
- Undefined: counters are cleared only by rst, which gives incremental training across finalizes.

## Structure
- Package am_trainer_pkg:
  - State enum (IDLE, ACCUM, THRESH, OUT).
  - Class id localparams (V_PLUS=0, V_MIN=1, A_HIGH=2, A_LOW=3).
  - Saturation max constant derived from COUNT_WIDTH.
- Sub-module hv_majority_fold, combinational:
  - Inputs: AM_FOLD_WIDTH counters of COUNT_WIDTH bits, plus n.
  - Output: AM_FOLD_WIDTH threshold bits.
  - Instantiated once and muxed by class and fold.

## Test plan
- Single sample with hvin = all ones, valence 1, arousal 0, then finalize.
  - Expect id 0 = all ones, id 1 = all zeros, id 2 = all zeros, id 3 = all ones.
  - Expect first proto_valid AM_NUM_FOLDS+1 cycles after the finalize fire.
- Three V_PLUS samples A, A, B with A = 0xAA.. pattern and B = ~A: prototype 0 equals A (2 of 3 majority).
- Two V_PLUS samples A and ~A: tie, so prototype 0 is all zeros.
- Simultaneous hvin_valid and finalize_valid in IDLE: finalize accepted, hvin_ready 0; the sample is accepted only after the id 3 handshake.
- Hold proto_ready low for 20 cycles at id 1: proto_hv and proto_id stable, proto_valid held, no further counter or state change.
- 300 all-ones V_PLUS samples with COUNT_WIDTH 8:
  - n[0] saturates at 255; prototype 0 is all ones.
  - With AM_TRAINER_AUTOCLEAR_EN: a second finalize without new samples yields four all-zero prototypes.
  - Without it: the second finalize repeats the first result.
